// File: rtl/friscv_inst_dispatcher_pkg.sv
// rtl/friscv_inst_dispatcher_pkg.sv - shared types and constants for the instruction dispatcher
// Opcode helpers exist only when FRISCV_DISPATCH_BRSTOP_EN is defined.
package friscv_inst_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_STALL,
    ST_BRWAIT
  } state_t;

  localparam int INST_BYTES = 4;

`ifdef FRISCV_DISPATCH_BRSTOP_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic is_ctrl_flow(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction
`endif

endpackage

// File: rtl/friscv_scfifo.sv
// rtl/friscv_scfifo.sv - single-clock FIFO with synchronous clear and occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module friscv_scfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push)   wptr_d = wptr_q + AW'(1);
      if (do_pop) rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && !clear && push) mem_q[wptr_q] <= wdata;
  end

  // A push into a full queue is only legal when a pop frees the slot the same cycle
  assert property (@(posedge clk) disable iff (srst || clear)
    !(push && !do_pop && (count_q == (AW+1)'(DEPTH))));

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/friscv_inst_dispatcher.sv
// rtl/friscv_inst_dispatcher.sv - credit-based instruction fetch and dispatch front-end
// FRISCV_DISPATCH_BRSTOP_EN stops fetching after a pushed branch/jump until a flush.
module friscv_inst_dispatcher
  import friscv_inst_dispatcher_pkg::*;
#(
  parameter int               ADDRW           = 16,
  parameter int               XLEN            = 32,
  parameter logic [ADDRW-1:0] BOOT_ADDR       = '0,
  parameter int               FIFO_DEPTH      = 8,
  parameter int               MAX_OUTSTANDING = 4
) (
  input  logic             aclk,
  input  logic             srst,
  output logic             inst_en,
  output logic [ADDRW-1:0] inst_addr,
  input  logic             inst_ready,
  input  logic [XLEN-1:0]  inst_rdata,
  output logic             dis_valid,
  input  logic             dis_ready,
  output logic [XLEN-1:0]  dis_inst,
  output logic [ADDRW-1:0] dis_pc,
  input  logic             flush,
  input  logic [ADDRW-1:0] flush_addr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  state_t                 state_q, state_d;
  logic                   inst_en_q, inst_en_d;
  logic [ADDRW-1:0]       inst_addr_q, inst_addr_d;
  logic [ADDRW-1:0]       pc_q, pc_d, resp_pc_q, resp_pc_d, base_pc;
  logic [OW-1:0]          outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0]          count, count_nxt;
  logic [ADDRW+XLEN-1:0]  fifo_rdata;
  logic                   push, pop, can_issue, br_stop;

  always_comb begin
    pop       = dis_valid && dis_ready;
    push      = inst_ready && (drop_q == '0) && !flush;
    // In-flight count after this cycle, including the request on the bus now
    outst_d   = outst_q + OW'(inst_en_q) - OW'(inst_ready);
    count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
    can_issue = (int'(outst_d) + int'(count_nxt) < FIFO_DEPTH) &&
                (int'(outst_d) < MAX_OUTSTANDING);
`ifdef FRISCV_DISPATCH_BRSTOP_EN
    br_stop   = push && is_ctrl_flow(inst_rdata[6:0]);
`else
    br_stop   = 1'b0;
`endif

    state_d = state_q;
    if (flush)                                 state_d = can_issue ? ST_FETCH : ST_STALL;
    else if (state_q == ST_BRWAIT || br_stop)  state_d = ST_BRWAIT;
    else                                       state_d = can_issue ? ST_FETCH : ST_STALL;
    inst_en_d = (state_d == ST_FETCH);

    base_pc     = flush ? flush_addr : pc_q;
    pc_d        = inst_en_d ? base_pc + ADDRW'(INST_BYTES) : base_pc;
    inst_addr_d = inst_en_d ? base_pc : inst_addr_q;

    // Responses return in order, so the tag of the next kept word is a running counter
    resp_pc_d = resp_pc_q;
    if (flush)     resp_pc_d = flush_addr;
    else if (push) resp_pc_d = resp_pc_q + ADDRW'(INST_BYTES);

    drop_d = drop_q;
    if (flush)                            drop_d = outst_d;
    else if (inst_ready && drop_q != '0)  drop_d = drop_q - OW'(1);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= ST_BOOT;
      inst_en_q   <= 1'b0;
      inst_addr_q <= BOOT_ADDR;
      pc_q        <= BOOT_ADDR;
      resp_pc_q   <= BOOT_ADDR;
      outst_q     <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      inst_en_q   <= inst_en_d;
      inst_addr_q <= inst_addr_d;
      pc_q        <= pc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
    end
  end

  friscv_scfifo #(
    .WIDTH (ADDRW + XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk   (aclk),
    .srst  (srst),
    .clear (flush),
    .push  (push),
    .wdata ({resp_pc_q, inst_rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign inst_en           = inst_en_q;
  assign inst_addr         = inst_addr_q;
  assign dis_valid         = (count != '0);
  assign {dis_pc, dis_inst} = dis_valid ? fifo_rdata : '0;

endmodule

// File: tb/tb_friscv_inst_dispatcher.sv
// tb/tb_friscv_inst_dispatcher.sv - self-checking bench for friscv_inst_dispatcher
// Branch-stop sequence runs only when FRISCV_DISPATCH_BRSTOP_EN is defined.
module tb_friscv_inst_dispatcher;

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic        inst_en, inst_ready, dis_valid, dis_ready, flush;
  logic [15:0] inst_addr, dis_pc, flush_addr;
  logic [31:0] inst_rdata, dis_inst;

  always #5 aclk = ~aclk;

  friscv_inst_dispatcher #(
    .ADDRW           (16),
    .XLEN            (32),
    .BOOT_ADDR       (16'h0000),
    .FIFO_DEPTH      (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .aclk       (aclk),
    .srst       (srst),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready),
    .inst_rdata (inst_rdata),
    .dis_valid  (dis_valid),
    .dis_ready  (dis_ready),
    .dis_inst   (dis_inst),
    .dis_pc     (dis_pc),
    .flush      (flush),
    .flush_addr (flush_addr)
  );

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
    logic        dv;
    logic [15:0] pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          hs_cnt = 0;
  bit          br_test = 1'b0;
  logic [15:0] exp_pc = '0;
  logic [15:0] last_hs_pc = '0;
  logic [15:0] req_addr_q[$];
  int          req_due_q[$];
  logic [15:0] issued_q[$];
  vec_t        tv[11];

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    if (br_test && a == 16'h0008) return 32'h0000_0063;
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called mid-cycle: scoreboard the pending handshake, drive memory, advance one cycle
  task automatic step();
    if (dis_valid && dis_ready) begin
      chk("dis_pc", 32'(dis_pc), 32'(exp_pc));
      chk("dis_inst", dis_inst, mem_data(exp_pc));
      last_hs_pc = dis_pc;
      hs_cnt++;
      exp_pc = exp_pc + 16'd4;
    end
    if (flush) exp_pc = flush_addr;
    inst_ready = 1'b0;
    inst_rdata = '0;
    if (req_due_q.size() > 0 && req_due_q[0] == cyc) begin
      inst_ready = 1'b1;
      inst_rdata = mem_data(req_addr_q[0]);
      void'(req_due_q.pop_front());
      void'(req_addr_q.pop_front());
    end
    if (inst_en) begin
      req_addr_q.push_back(inst_addr);
      req_due_q.push_back(cyc + lat);
      issued_q.push_back(inst_addr);
    end
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    flush = 1'b0;
    flush_addr = '0;
    dis_ready = 1'b0;
    inst_ready = 1'b0;
    inst_rdata = '0;
    req_addr_q.delete();
    req_due_q.delete();
    issued_q.delete();
    repeat (3) @(negedge aclk);
    srst = 1'b0;
    cyc = 0;
    exp_pc = '0;
    hs_cnt = 0;
  endtask

  initial begin
    tv[0]  = '{en: 1'b0, addr: 16'h0000, dv: 1'b0, pc: 16'h0000};
    tv[1]  = '{en: 1'b1, addr: 16'h0000, dv: 1'b0, pc: 16'h0000};
    tv[2]  = '{en: 1'b1, addr: 16'h0004, dv: 1'b0, pc: 16'h0000};
    tv[3]  = '{en: 1'b1, addr: 16'h0008, dv: 1'b1, pc: 16'h0000};
    tv[4]  = '{en: 1'b1, addr: 16'h000C, dv: 1'b1, pc: 16'h0004};
    tv[5]  = '{en: 1'b1, addr: 16'h0010, dv: 1'b1, pc: 16'h0008};
    tv[6]  = '{en: 1'b1, addr: 16'h0014, dv: 1'b1, pc: 16'h000C};
    tv[7]  = '{en: 1'b1, addr: 16'h0018, dv: 1'b1, pc: 16'h0010};
    tv[8]  = '{en: 1'b1, addr: 16'h001C, dv: 1'b1, pc: 16'h0014};
    tv[9]  = '{en: 1'b1, addr: 16'h0020, dv: 1'b1, pc: 16'h0018};
    tv[10] = '{en: 1'b1, addr: 16'h0024, dv: 1'b1, pc: 16'h001C};

    // Reset state
    flush = 1'b0; flush_addr = '0; dis_ready = 1'b0; inst_ready = 1'b0; inst_rdata = '0;
    repeat (3) @(negedge aclk);
    chk("rst_inst_en", 32'(inst_en), 32'h0);
    chk("rst_inst_addr", 32'(inst_addr), 32'h0);
    chk("rst_dis_valid", 32'(dis_valid), 32'h0);
    chk("rst_dis_inst", dis_inst, 32'h0);
    chk("rst_dis_pc", 32'(dis_pc), 32'h0);

    // Streaming, latency 1, ALU always ready
    do_reset();
    lat = 1;
    dis_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      chk("vec_en", 32'(inst_en), 32'(tv[k].en));
      if (tv[k].en) chk("vec_addr", 32'(inst_addr), 32'(tv[k].addr));
      chk("vec_dv", 32'(dis_valid), 32'(tv[k].dv));
      if (tv[k].dv) chk("vec_pc", 32'(dis_pc), 32'(tv[k].pc));
      step();
    end

    // Back-pressure: credits cap the total at FIFO_DEPTH, then drain in order
    do_reset();
    lat = 3;
    dis_ready = 1'b0;
    repeat (30) step();
    chk("stall_issued", 32'(issued_q.size()), 32'd8);
    chk("stall_last_addr", 32'(issued_q[7]), 32'h1C);
    chk("stall_inst_en", 32'(inst_en), 32'h0);
    chk("stall_dv", 32'(dis_valid), 32'h1);
    chk("stall_head_pc", 32'(dis_pc), 32'h0);
    dis_ready = 1'b1;
    for (int i = 0; i < 60 && hs_cnt < 8; i++) step();
    chk("drain_count", 32'(hs_cnt), 32'd8);
    chk("resume_addr", issued_q.size() > 8 ? 32'(issued_q[8]) : 32'hFFFF_FFFF, 32'h20);
    repeat (10) step();

    // Flush with three requests in flight
    do_reset();
    lat = 3;
    dis_ready = 1'b1;
    repeat (3) step();
    chk("f3_pre_addr", 32'(inst_addr), 32'h8);
    flush = 1'b1; flush_addr = 16'h0100;
    step();
    flush = 1'b0;
    chk("f3_en", 32'(inst_en), 32'h1);
    chk("f3_addr", 32'(inst_addr), 32'h100);
    for (int i = 0; i < 4; i++) begin
      chk("f3_drop_dv", 32'(dis_valid), 32'h0);
      step();
    end
    chk("f3_dv", 32'(dis_valid), 32'h1);
    chk("f3_pc", 32'(dis_pc), 32'h100);
    repeat (6) step();

    // Flush together with a dispatch handshake and a memory response
    do_reset();
    lat = 1;
    dis_ready = 1'b1;
    repeat (5) step();
    chk("f4_pre_pc", 32'(dis_pc), 32'h8);
    flush = 1'b1; flush_addr = 16'h0200;
    step();
    flush = 1'b0;
    chk("f4_consumed", 32'(last_hs_pc), 32'h8);
    chk("f4_empty", 32'(dis_valid), 32'h0);
    chk("f4_addr", 32'(inst_addr), 32'h200);
    step();
    chk("f4_dv_f2", 32'(dis_valid), 32'h0);
    step();
    chk("f4_dv_f3", 32'(dis_valid), 32'h1);
    chk("f4_pc", 32'(dis_pc), 32'h200);
    repeat (3) step();

    // Address wrap at the top of the space
    flush = 1'b1; flush_addr = 16'hFFFC;
    step();
    flush = 1'b0;
    chk("wrap_addr0", 32'(inst_addr), 32'hFFFC);
    step();
    chk("wrap_addr1", 32'(inst_addr), 32'h0000);
    repeat (6) step();

`ifdef FRISCV_DISPATCH_BRSTOP_EN
    do_reset();
    br_test = 1'b1;
    lat = 1;
    dis_ready = 1'b1;
    repeat (10) step();
    chk("br_issued", 32'(issued_q.size()), 32'd4);
    chk("br_last_addr", issued_q.size() > 3 ? 32'(issued_q[3]) : 32'hFFFF_FFFF, 32'hC);
    chk("br_en", 32'(inst_en), 32'h0);
    flush = 1'b1; flush_addr = 16'h0040;
    step();
    flush = 1'b0;
    chk("br_resume_en", 32'(inst_en), 32'h1);
    chk("br_resume_addr", 32'(inst_addr), 32'h40);
    repeat (6) step();
    br_test = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
